// File: rtl/mux_scan_reg.sv
// rtl/mux_scan_reg.sv - registered N-channel mux with manual select and auto-scan modes
module mux_scan_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1,
    localparam int SEL_W   = $clog2(CHANNELS),
    localparam int DC_W    = $clog2(DWELL + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [WIDTH-1:0]          q,
    output logic [SEL_W-1:0]          q_ch,
    output logic                      q_valid,
    output logic                      wrap
);

    // Slots beyond CHANNELS read as zero so an out-of-range select yields q=0.
    localparam int NSLOT = 1 << SEL_W;
    localparam logic [SEL_W:0]   CH_COUNT = CHANNELS[SEL_W:0];
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DWELL - 1);

    logic [WIDTH-1:0] slot [NSLOT];

    // Unpack the channel bus, padding unused slots with zero.
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i < CHANNELS) begin : g_real
            assign slot[i] = d[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign slot[i] = '0;
        end
    end

    logic [SEL_W-1:0] ch;
    logic [DC_W-1:0]  dc;
    logic             mode_d;
    logic             armed;

    logic             restart;
    logic [SEL_W-1:0] eff_ch;
    logic [DC_W-1:0]  eff_dc;
    logic [SEL_W-1:0] next_ch;
    logic [DC_W-1:0]  next_dc;
    logic             scan_last;
    logic             sel_ok;

    // Scan position actually sampled this edge (forced to 0/0 on scan entry) and its successor.
    always_comb begin
        restart   = ~mode_d | armed;
        eff_ch    = restart ? '0 : ch;
        eff_dc    = restart ? '0 : dc;
        scan_last = (eff_ch == CH_LAST) && (eff_dc == DC_LAST);
        sel_ok    = ({1'b0, sel} < CH_COUNT);
        next_ch   = eff_ch;
        next_dc   = eff_dc + DC_W'(1);
        if (eff_dc == DC_LAST) begin
            next_dc = '0;
            next_ch = (eff_ch == CH_LAST) ? '0 : eff_ch + SEL_W'(1);
        end
    end

    // Output register plus scan counter, mode history and restart flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_ch    <= '0;
            q_valid <= 1'b0;
            wrap    <= 1'b0;
            ch      <= '0;
            dc      <= '0;
            mode_d  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            mode_d <= mode;
            if (en) begin
                if (!mode) begin
                    q       <= slot[sel];
                    q_ch    <= sel;
                    q_valid <= sel_ok;
                    wrap    <= 1'b0;
                    ch      <= '0;
                    dc      <= '0;
                    armed   <= 1'b0;
                end else begin
                    q       <= slot[eff_ch];
                    q_ch    <= eff_ch;
                    q_valid <= 1'b1;
                    wrap    <= scan_last;
                    ch      <= next_ch;
                    dc      <= next_dc;
                    armed   <= 1'b0;
                end
            end else begin
                q_valid <= 1'b0;
                wrap    <= 1'b0;
                armed   <= armed | (mode & ~mode_d);
            end
        end
    end

endmodule
